nav_turn_queue: RTL

NAV_TURN_QUEUE -- requirements
Module: nav_turn_queue

---
 rtl/nav_pkg.sv | 16 +
 rtl/nav_turn_fifo.sv | 81 ++++++++
 rtl/nav_turn_queue.sv | 99 +++++++++
 3 files changed

// File: rtl/nav_pkg.sv
// Direction encoding shared by the turn queue and its per-player FIFO.
package nav_pkg;

    typedef logic [1:0] nav_dir_t;

    localparam nav_dir_t DIR_UP    = 2'd0;
    localparam nav_dir_t DIR_LEFT  = 2'd1;
    localparam nav_dir_t DIR_RIGHT = 2'd2;
    localparam nav_dir_t DIR_DOWN  = 2'd3;

    // Codes are arranged so that a reversal is a bitwise inversion.
    function automatic nav_dir_t opposite(input nav_dir_t d);
        return d ^ 2'b11;
    endfunction

endpackage

// File: rtl/nav_turn_fifo.sv
// Small circular FIFO of pending turns for one player; exposes both the
// oldest entry (next to commit) and the newest entry (validation reference).
module nav_turn_fifo
    import nav_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     CLK,
    input  logic     RESET,
    input  logic     push,
    input  logic     pop,
    input  nav_dir_t push_dir,
    output nav_dir_t head,
    output nav_dir_t tail,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

    nav_dir_t         mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             full_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal when the same edge frees a slot.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && (!full_q || do_pop);

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
        end else begin
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            count  <= count_nxt;
            full_q <= (count_nxt == CNT_MAX);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DIR_UP;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_dir;
        end
    end

    assign tail_ptr = (wr_ptr == '0) ? PTR_LAST : wr_ptr - 1'b1;
    assign head     = mem[rd_ptr];
    assign tail     = mem[tail_ptr];
    assign full     = full_q;
    assign empty    = (count == '0);

endmodule

// File: rtl/nav_turn_queue.sv
// Per-player button-to-direction turn queue: edge-detects buttons, rejects
// no-op and reversing turns, and commits one queued turn per game TICK.
module nav_turn_queue
    import nav_pkg::*;
#(
    parameter int         NUM_PLAYERS = 1,
    parameter int         QUEUE_DEPTH = 2,
    parameter logic [1:0] RESET_DIR   = 2'd0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     TICK,
    input  logic                     ENABLE,
    input  logic [4*NUM_PLAYERS-1:0] BTN,
    output logic [2*NUM_PLAYERS-1:0] NAV_STATE,
    output logic [NUM_PLAYERS-1:0]   DIR_CHANGED,
    output logic [NUM_PLAYERS-1:0]   QUEUE_FULL
);

    logic [4*NUM_PLAYERS-1:0] btn_prev;

    // All-ones after reset so a button held through reset is not an edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            btn_prev <= '1;
        end else begin
            btn_prev <= BTN;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [3:0] btn_rise;
        logic       req_any;
        nav_dir_t   req_dir;
        nav_dir_t   ref_dir;
        nav_dir_t   head_dir;
        nav_dir_t   tail_dir;
        nav_dir_t   nav_q;
        logic       req_valid;
        logic       do_pop;
        logic       do_push;
        logic       fifo_full;
        logic       fifo_empty;
        logic       changed_q;

        assign btn_rise = BTN[4*p +: 4] & ~btn_prev[4*p +: 4];
        assign req_any  = |btn_rise;

        always_comb begin
            req_dir = DIR_UP;
            if (btn_rise[0]) begin
                req_dir = DIR_UP;
            end else if (btn_rise[1]) begin
                req_dir = DIR_LEFT;
            end else if (btn_rise[2]) begin
                req_dir = DIR_RIGHT;
            end else if (btn_rise[3]) begin
                req_dir = DIR_DOWN;
            end
        end

        // Validate against where the snake will be heading once the queue drains.
        assign ref_dir   = fifo_empty ? nav_q : tail_dir;
        assign req_valid = req_any && (req_dir != ref_dir) && (req_dir != opposite(ref_dir));
        assign do_pop    = ENABLE && TICK && !fifo_empty;
        assign do_push   = ENABLE && req_valid && (!fifo_full || do_pop);

        nav_turn_fifo #(
            .DEPTH (QUEUE_DEPTH)
        ) u_fifo (
            .CLK      (CLK),
            .RESET    (RESET),
            .push     (do_push),
            .pop      (do_pop),
            .push_dir (req_dir),
            .head     (head_dir),
            .tail     (tail_dir),
            .full     (fifo_full),
            .empty    (fifo_empty)
        );

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                nav_q     <= RESET_DIR;
                changed_q <= 1'b0;
            end else begin
                changed_q <= do_pop && (head_dir != nav_q);
                if (do_pop) begin
                    nav_q <= head_dir;
                end
            end
        end

        assign NAV_STATE[2*p +: 2] = nav_q;
        assign DIR_CHANGED[p]      = changed_q;
        assign QUEUE_FULL[p]       = fifo_full;
    end

endmodule
